// File: rtl/aes_alg_arbiter.sv
// Round-robin arbiter sharing one aes_top cipher core between two block-mode requesters.
// One operation in flight at a time; results and done pulses are routed back to the owner.
module aes_alg_arbiter #(
    parameter int BLK_BITS = 128,
    parameter int TIMEOUT  = 63
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                req0_cipher,
    input  logic                req0_decipher,
    input  logic [BLK_BITS-1:0] req0_in_blk,
    output logic                req0_ack,
    output logic                req0_done,

    input  logic                req1_cipher,
    input  logic                req1_decipher,
    input  logic [BLK_BITS-1:0] req1_in_blk,
    output logic                req1_ack,
    output logic                req1_done,

    input  logic                key_busy,

    output logic                aes_en_cipher,
    output logic                aes_en_decipher,
    output logic [BLK_BITS-1:0] aes_in_blk,
    input  logic [BLK_BITS-1:0] aes_out_blk,
    input  logic                aes_done,

    output logic [BLK_BITS-1:0] out_blk,
    output logic                owner,
    output logic                busy,
    output logic                err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Counter value on the last WAIT cycle before the operation is abandoned.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    logic       last;
    logic [7:0] wait_cnt;

    logic       valid0;
    logic       valid1;
    logic       grant_any;
    logic       grant_id;
    logic       grant_cipher;

    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        valid0       = req0_cipher | req0_decipher;
        valid1       = req1_cipher | req1_decipher;
        grant_any    = ~key_busy & (valid0 | valid1);
        grant_id     = 1'b0;
        if (valid0 && valid1) begin
            grant_id = ~last;
        end else begin
            grant_id = valid1;
        end
        // Cipher takes precedence when a requester raises both operation bits.
        grant_cipher = grant_id ? req1_cipher : req0_cipher;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            last            <= 1'b1;
            wait_cnt        <= '0;
            owner           <= 1'b0;
            busy            <= 1'b0;
            err             <= 1'b0;
            req0_ack        <= 1'b0;
            req1_ack        <= 1'b0;
            req0_done       <= 1'b0;
            req1_done       <= 1'b0;
            aes_en_cipher   <= 1'b0;
            aes_en_decipher <= 1'b0;
            // NOTE: the block registers are reset too, because their zero value is
            // architecturally visible after reset rather than a don't-care.
            aes_in_blk      <= '0;
            out_blk         <= '0;
        end else begin
            req0_ack        <= 1'b0;
            req1_ack        <= 1'b0;
            req0_done       <= 1'b0;
            req1_done       <= 1'b0;
            aes_en_cipher   <= 1'b0;
            aes_en_decipher <= 1'b0;
            err             <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner           <= grant_id;
                        aes_in_blk      <= grant_id ? req1_in_blk : req0_in_blk;
                        aes_en_cipher   <= grant_cipher;
                        aes_en_decipher <= ~grant_cipher;
                        req0_ack        <= ~grant_id;
                        req1_ack        <= grant_id;
                        busy            <= 1'b1;
                        state           <= ISSUE;
                    end
                end

                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end

                WAIT: begin
                    if (aes_done) begin
                        out_blk   <= aes_out_blk;
                        req0_done <= ~owner;
                        req1_done <= owner;
                        state     <= RESP;
                    end else if (wait_cnt == LAST_WAIT) begin
                        err   <= 1'b1;
                        last  <= owner;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                RESP: begin
                    last  <= owner;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_alg_arbiter.sv
// Scoreboard bench for aes_alg_arbiter: a behavioural core model answers operations,
// a grant/response monitor compares the DUT against a round-robin reference.
module tb_aes_alg_arbiter;

    localparam int BLK = 128;
    localparam int TMO = 8;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] MASK = 128'hc3a55a3c0ff0e11e96697887d22d4bb4;

    typedef struct {
        bit           is_err;
        bit           id;
        logic [127:0] res;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           rc [2];
    logic           rd [2];
    logic [BLK-1:0] rb [2];
    logic           key_busy;
    logic           req0_ack, req0_done, req1_ack, req1_done;
    logic           aes_en_cipher, aes_en_decipher, aes_done;
    logic [BLK-1:0] aes_in_blk, aes_out_blk, out_blk;
    logic           owner, busy, err;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    int   grant_log[$];
    bit   stall = 1'b0;
    int   lat_override = 0;
    int   cur_lat = 1;
    int   n_ack [2];
    int   n_done [2];
    int   n_err = 0;

    always #5 clk = ~clk;

    aes_alg_arbiter #(.BLK_BITS(BLK), .TIMEOUT(TMO)) dut (
        .clk             (clk),
        .reset           (rst_n),
        .req0_cipher     (rc[0]),
        .req0_decipher   (rd[0]),
        .req0_in_blk     (rb[0]),
        .req0_ack        (req0_ack),
        .req0_done       (req0_done),
        .req1_cipher     (rc[1]),
        .req1_decipher   (rd[1]),
        .req1_in_blk     (rb[1]),
        .req1_ack        (req1_ack),
        .req1_done       (req1_done),
        .key_busy        (key_busy),
        .aes_en_cipher   (aes_en_cipher),
        .aes_en_decipher (aes_en_decipher),
        .aes_in_blk      (aes_in_blk),
        .aes_out_blk     (aes_out_blk),
        .aes_done        (aes_done),
        .out_blk         (out_blk),
        .owner           (owner),
        .busy            (busy),
        .err             (err)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stand-in cipher: the real FIPS-197 pair, otherwise an invertible swap-and-mask.
    function automatic logic [127:0] xform(input logic [127:0] b, input logic c);
        if (c && b == PT) return CT;
        if (!c && b == CT) return PT;
        if (c) return {b[63:0], b[127:64]} ^ MASK;
        return {b[63:0], b[127:64]} ^ {MASK[63:0], MASK[127:64]};
    endfunction

    function automatic logic [127:0] rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Core model: sees the enable during ISSUE, answers after a random latency.
    logic [127:0] core_b;
    logic         core_c;
    int           core_l;
    initial begin
        aes_done    = 1'b0;
        aes_out_blk = '0;
        forever begin
            @(negedge clk);
            if (rst_n && (aes_en_cipher || aes_en_decipher) && !stall) begin
                core_b  = aes_in_blk;
                core_c  = aes_en_cipher;
                core_l  = (lat_override != 0) ? lat_override : int'($urandom_range(1, 6));
                cur_lat = core_l;
                @(posedge clk);
                repeat (core_l - 1) @(posedge clk);
                #1;
                aes_done    = 1'b1;
                aes_out_blk = xform(core_b, core_c);
                @(posedge clk);
                #1;
                aes_done    = 1'b0;
                aes_out_blk = rnd_blk();
            end
        end
    end

    // Monitor: reference round-robin grant model and response scoreboard.
    logic         pv [2];
    logic         pc [2];
    logic [127:0] pb [2];
    logic         pkb;
    bit           model_last = 1'b1;
    int           since = 0;
    exp_t         mon_e;
    bit           mon_g;
    logic         mon_c;

    always @(negedge clk) begin
        since++;
        if (!rst_n) begin
            model_last = 1'b1;
        end else begin
            if ((aes_en_cipher || aes_en_decipher) && !(req0_ack || req1_ack))
                check("en_without_ack", 128'({aes_en_cipher, aes_en_decipher}), 128'(0));
            if (req0_ack || req1_ack) begin
                if (req0_ack) n_ack[0]++;
                if (req1_ack) n_ack[1]++;
                check("ack_onehot", 128'(req0_ack & req1_ack), 128'(0));
                check("grant_allowed", 128'({pkb, pv[0] | pv[1]}), 128'(2'b01));
                mon_g = (pv[0] && pv[1]) ? ~model_last : pv[1];
                mon_c = pc[mon_g];
                check("grant_id", 128'(req1_ack), 128'(mon_g));
                check("owner_at_ack", 128'(owner), 128'(mon_g));
                check("en_op", 128'({aes_en_cipher, aes_en_decipher}), 128'({mon_c, ~mon_c}));
                check("issue_blk", aes_in_blk, pb[mon_g]);
                check("busy_issue", 128'(busy), 128'(1));
                mon_e.is_err = stall;
                mon_e.id     = mon_g;
                mon_e.res    = xform(pb[mon_g], mon_c);
                sb.push_back(mon_e);
                grant_log.push_back(int'(mon_g));
                since = 0;
            end
            if (req0_done || req1_done || err) begin
                if (req0_done) n_done[0]++;
                if (req1_done) n_done[1]++;
                if (err) n_err++;
                if (sb.size() == 0) begin
                    check("unexpected_resp", 128'({req0_done, req1_done, err}), 128'(0));
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.is_err) begin
                        check("err_resp", 128'({req0_done, req1_done, err}), 128'(3'b001));
                        check("err_latency", 128'(since), 128'(TMO + 1));
                        check("busy_after_err", 128'(busy), 128'(0));
                    end else begin
                        check("done_resp", 128'({req0_done, req1_done, err}),
                              mon_e.id ? 128'(3'b010) : 128'(3'b100));
                        check("owner_at_done", 128'(owner), 128'(mon_e.id));
                        check("out_blk", out_blk, mon_e.res);
                        check("done_latency", 128'(since), 128'(cur_lat + 1));
                        check("busy_resp", 128'(busy), 128'(1));
                    end
                    model_last = mon_e.id;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            pv[i] = rc[i] | rd[i];
            pc[i] = rc[i];
            pb[i] = rb[i];
        end
        pkb = key_busy;
    end

    task automatic do_req(input int id, input logic c, input logic d, input logic [127:0] b,
                          output bit got);
        rc[id] = c;
        rd[id] = d;
        rb[id] = b;
        got    = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk);
            #1;
            if ((id == 0) ? req0_ack : req1_ack) got = 1'b1;
        end
        check("ack_wait", 128'(got), 128'(1));
        @(posedge clk);
        #1;
        rc[id] = 1'b0;
        rd[id] = 1'b0;
    endtask

    task automatic wait_quiet();
        int n = 0;
        while ((busy || sb.size() != 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("quiet_wait", 128'(n < 200), 128'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic rand_requester(input int id);
        bit got;
        int kind;
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            kind = int'($urandom_range(0, 3));
            if (kind == 3) begin
                rc[id] = 1'b1;
                rb[id] = rnd_blk();
                @(posedge clk);
                #1;
                rc[id] = 1'b0;
            end else begin
                do_req(id, kind != 1, kind != 0, rnd_blk(), got);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    bit g0, g1, g2, rand_fin;
    int acks_before;
    initial begin
        rst_n    = 1'b0;
        key_busy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rc[i] = 1'b0; rd[i] = 1'b0; rb[i] = '0;
            n_ack[i] = 0; n_done[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", 128'({req0_ack, req0_done, req1_ack, req1_done, aes_en_cipher,
                                  aes_en_decipher, owner, busy, err}), 128'(0));
        check("reset_out_blk", out_blk, 128'(0));
        check("reset_aes_in_blk", aes_in_blk, 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single cipher with the FIPS-197 vector.
        do_req(0, 1'b1, 1'b0, PT, g0);
        wait_quiet();
        check("single_result", out_blk, CT);
        check("single_counts", 128'({n_ack[0], n_done[0], n_ack[1], n_done[1]}),
              128'({32'd1, 32'd1, 32'd0, 32'd0}));

        // Both operation bits raised: cipher wins.
        do_req(0, 1'b1, 1'b1, rnd_blk(), g0);
        wait_quiet();

        // Key expansion blocks the grant; issue one cycle after it falls.
        key_busy    = 1'b1;
        rd[1]       = 1'b1;
        rb[1]       = CT;
        acks_before = n_ack[1];
        repeat (20) @(posedge clk);
        #1;
        check("kb_no_ack", 128'(n_ack[1]), 128'(acks_before));
        key_busy = 1'b0;
        @(posedge clk);
        #1;
        check("kb_issue_next", 128'(req1_ack), 128'(1));
        @(posedge clk);
        #1;
        rd[1] = 1'b0;
        wait_quiet();
        check("kb_decipher", out_blk, PT);

        // A request withdrawn while blocked is never granted.
        key_busy    = 1'b1;
        rc[0]       = 1'b1;
        rb[0]       = rnd_blk();
        acks_before = n_ack[0];
        repeat (3) @(posedge clk);
        #1;
        rc[0]    = 1'b0;
        key_busy = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("withdraw_no_ack", 128'(n_ack[0]), 128'(acks_before));

        // Timeout: the core never answers.
        stall = 1'b1;
        do_req(0, 1'b1, 1'b0, rnd_blk(), g0);
        repeat (TMO + 4) @(posedge clk);
        #1;
        check("timeout_err_count", 128'(n_err), 128'(1));
        stall = 1'b0;
        do_req(1, 1'b1, 1'b0, rnd_blk(), g1);
        wait_quiet();

        // Asynchronous reset in the middle of WAIT.
        lat_override = 6;
        do_req(0, 1'b1, 1'b0, rnd_blk(), g0);
        rst_n = 1'b0;
        #1;
        check("midreset_ctrl", 128'({req0_ack, req0_done, req1_ack, req1_done, aes_en_cipher,
                                     aes_en_decipher, owner, busy, err}), 128'(0));
        check("midreset_out_blk", out_blk, 128'(0));
        check("midreset_aes_in_blk", aes_in_blk, 128'(0));
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n        = 1'b1;
        lat_override = 0;
        repeat (10) @(posedge clk);
        #1;
        check("midreset_idle", 128'(busy), 128'(0));

        // Contention straight after reset: grants alternate starting with requester 0.
        grant_log.delete();
        fork
            begin
                for (int k = 0; k < 2; k++) do_req(0, 1'b1, 1'b0, rnd_blk(), g1);
            end
            begin
                for (int k = 0; k < 2; k++) do_req(1, 1'b1, 1'b0, rnd_blk(), g2);
            end
        join
        wait_quiet();
        check("contention_len", 128'(grant_log.size()), 128'(4));
        if (grant_log.size() == 4)
            for (int i = 0; i < 4; i++)
                check("contention_order", 128'(grant_log[i]), 128'(i % 2));

        // Randomised traffic with random key-expansion windows.
        rand_fin = 1'b0;
        fork
            begin
                fork
                    rand_requester(0);
                    rand_requester(1);
                join
                rand_fin = 1'b1;
            end
            begin
                while (!rand_fin) begin
                    @(posedge clk);
                    #1;
                    key_busy = ($urandom_range(0, 9) == 0);
                end
                key_busy = 1'b0;
            end
        join
        wait_quiet();
        check("final_sb_empty", 128'(sb.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_alg_arbiter.md
# aes_alg_arbiter

Shares one `aes_top` cipher core between two block-mode requesters, for example the GCM engine and a second mode engine. Each request carries an operation type and an input block. The arbiter grants requests round-robin, launches one operation at a time on the core, and routes the result and a done pulse back to the owning requester. It sits between the mode engines and `aes_top` and never launches an operation while key expansion is in progress.

## Interface
Parameters:
- `BLK_BITS`, default 128: AES block width.
- `TIMEOUT`, default 63: maximum WAIT cycles before the operation is aborted. Legal range 1–255.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req0_cipher`  in  1  requester 0 requests encryption. Level; held until `req0_ack`.
- `req0_decipher`  in  1  requester 0 requests decryption. Level; held until `req0_ack`.
- `req0_in_blk`  in  BLK_BITS  requester 0 input block; stable while a request is asserted.
- `req0_ack`  out  1  one-cycle pulse: the request was launched on the core.
- `req0_done`  out  1  one-cycle pulse: `out_blk` holds requester 0's result.
- `req1_cipher`, `req1_decipher`, `req1_in_blk`, `req1_ack`, `req1_done`: same as above, for requester 1.
- `key_busy`  in  1  key expansion in progress; blocks new grants.
- `aes_en_cipher`  out  1  to core `en_cipher`.
- `aes_en_decipher`  out  1  to core `en_decipher`.
- `aes_in_blk`  out  BLK_BITS  to core `aes_in_blk`.
- `aes_out_blk`  in  BLK_BITS  from core.
- `aes_done`  in  1  from core `en_o`.
- `out_blk`  out  BLK_BITS  registered result, shared by both requesters.
- `owner`  out  1  index of the current or most recent grant.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  one-cycle pulse on timeout.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Requester N is valid when `reqN_cipher | reqN_decipher`.
  - If `key_busy` = 0 and at least one requester is valid, grant a requester:
    - one valid requester: grant it;
    - both valid: grant the requester whose index is not equal to `last`.
  - On a grant, latch the input block, the operation and `owner`, then go to ISSUE.
  - If both `cipher` and `decipher` are asserted, the request is treated as cipher.
- **ISSUE** (exactly one cycle)
  - `aes_en_cipher` or `aes_en_decipher` is high, matching the latched operation.
  - `aes_in_blk` equals the latched block.
  - `reqN_ack` is high for the owner.
  - Clear the timeout counter, then go to WAIT.
- **WAIT**
  - When `aes_done` is sampled high: capture `aes_out_blk` into `out_blk`, go to RESP.
  - Otherwise the counter increments. When it reaches `TIMEOUT`, pulse `err`, set `last` = `owner`, go to IDLE, and raise no done pulse.
- **RESP** (one cycle)
  - `reqN_done` is high for the owner.
  - Set `last` = `owner`, go to IDLE.
- Requests sampled in IDLE only. A requester may withdraw before it is granted.
- Requester must deassert its request in the cycle after `ack`. A request still asserted on the next IDLE is treated as a new request.
- `key_busy` rising during ISSUE, WAIT or RESP does not affect the in-flight operation.
- `aes_done` outside WAIT is ignored.
- `aes_in_blk` holds its last value outside ISSUE.

## Timing
- Reset values:
  - state = IDLE;
  - `last` = 1, so requester 0 wins the first contention;
  - `owner`, `busy`, `err`, all acks, all dones, `aes_en_*` = 0;
  - `out_blk` and `aes_in_blk` = 0.
- All outputs are registered.
- Edge E0 grants in IDLE. The ISSUE cycle follows E0. The core samples `aes_en_*` at E1.
- Edge Ed samples `aes_done` in WAIT. `reqN_done` and the valid `out_blk` appear in the cycle after Ed. The FSM returns to IDLE at Ed+1.
- Minimum request-to-done latency = core latency + 3 cycles.
- Back-to-back grants are separated by at least one IDLE cycle.
- An asynchronous reset mid-operation returns the block to IDLE immediately:
  - no done pulse is raised;
  - the core is not notified;
  - the integrator must also reset the core.

## Test plan
- **Single cipher:** expand key 000102…0f, then requester 0 cipher with block 00112233445566778899aabbccddeeff.
  - Expect `req0_ack` once, then `req0_done` once with `out_blk` = 69c4e0d86a7b0430d8cdb78070b4c55a.
  - `req1_*` outputs stay 0.
- **Contention:** both requesters continuously assert cipher for 4 operations.
  - Grants alternate 0, 1, 0, 1.
  - `owner` matches each done pulse.
  - Each `out_blk` matches its requester's input.
- **Key busy:** `key_busy` = 1 with `req1_decipher` = 1 for 20 cycles.
  - No `aes_en_*` and no ack while `key_busy` is high.
  - ISSUE occurs one cycle after `key_busy` falls.
  - Decipher of 69c4e0…c55a yields 00112233…eeff.
- **Timeout:** `TIMEOUT` = 8 and the core done is forced low.
  - `err` pulses on the 8th WAIT cycle; no done pulse.
  - The next request completes normally.
- **Reset mid-WAIT:** drop `reset` low between ISSUE and `aes_done`.
  - All outputs are 0 immediately.
  - After release, `busy` = 0, and the first contention is granted to requester 0.
- **Both ops set:** `req0_cipher` = `req0_decipher` = 1.
  - Only `aes_en_cipher` pulses.
